// File: rtl/icache_pkg.sv
//==============================================================================
// Module : icache_pkg
// Brief  : Shared types, constants and helpers for the instruction-cache
//          block-fill controller.
// Contents:
//   fill_state_t  - fill FSM state encoding (IDLE / FILL / TAG)
//   WORD_IDX_W    - bits needed to index a word within a block
//   OFFSET_W      - byte-offset bits of a block address
//   block_base()  - clears the block-offset bits of a byte address
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package icache_pkg;

   localparam int WORD_IDX_W = 3;
   localparam int OFFSET_W   = WORD_IDX_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_TAG  = 2'd2
   } fill_state_t;

   // Returns addr with its low off_w bits forced to zero (start of block).
   function automatic logic [63:0] block_base(input logic [63:0] addr,
                                              input int unsigned off_w);
      logic [63:0] mask;
      mask = (64'd1 << off_w) - 64'd1;
      return addr & ~mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fill_word_counter.sv
//==============================================================================
// Module : fill_word_counter
// Brief  : Word-sequence counter for one side (issue or return) of a block
//          fill. Counts accepted words, produces the current word index
//          (start offset + count, wrapping within the block) and a sticky
//          done flag that separates "0 words" from "all words".
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   i_clr    in   restart the sequence (count 0, done 0, index = i_start)
//   i_start  in   first word index of the sequence
//   i_en     in   one word accepted this cycle
//   o_idx    out  word index for the current position
//   o_last   out  current position is the final word of the block
//   o_done   out  all words of the block have been accepted
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module fill_word_counter
   import icache_pkg::*;
#(
   parameter int WIDTH = WORD_IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_start,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_idx,
   output logic             o_last,
   output logic             o_done
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_idx;
   logic             r_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_idx  <= '0;
         r_done <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_idx  <= i_start;
         r_done <= 1'b0;
      end else if (i_en && !r_done) begin
         // Count and index both wrap modulo the block size; the done flag
         // is what stops the sequence after the final word.
         r_cnt <= r_cnt + 1'b1;
         r_idx <= r_idx + 1'b1;
         if (r_cnt == '1) begin
            r_done <= 1'b1;
         end
      end
   end

   assign o_idx  = r_idx;
   assign o_last = (r_cnt == '1);
   assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/icache_fill_ctrl.sv
//==============================================================================
// Module : icache_fill_ctrl
// Brief  : Miss handler for the 2-way instruction cache. On a miss it
//          requests every word of the missing block from pipelined main
//          memory, streams the returned words into the cache data array and
//          finally writes the tag/valid entry, holding the cache busy until
//          the block is resident.
// Config : define ICACHE_FILL_CWF_EN for critical-word-first ordering (the
//          request/return sequence starts at the missed word and wraps
//          within the block). Undefined: sequence always starts at word 0.
// Ports:
//   clk              in   system clock
//   rst              in   asynchronous active-high reset
//   miss_detected    in   cache miss this cycle
//   miss_address     in   byte address that missed
//   mem_stall        in   memory cannot accept a request this cycle
//   mem_data_valid   in   memory_data carries a returned word
//   memory_data      in   returned word, in request order
//   fsm_busy         out  fill in progress
//   mem_en           out  read request issued this cycle
//   memory_address   out  byte address of the request
//   cache_addr       out  cache address for the current fill/tag write
//   fill_data        out  word to write into the cache data array
//   write_data_array out  write fill_data at cache_addr this cycle
//   write_tag_array  out  write tag/valid/LRU for cache_addr's block
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module icache_fill_ctrl
   import icache_pkg::*;
#(
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16,
   parameter int WORDS_PER_BLOCK = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              mem_stall,
   input  logic              mem_data_valid,
   input  logic [DATA_W-1:0] memory_data,
   output logic              fsm_busy,
   output logic              mem_en,
   output logic [ADDR_W-1:0] memory_address,
   output logic [ADDR_W-1:0] cache_addr,
   output logic [DATA_W-1:0] fill_data,
   output logic              write_data_array,
   output logic              write_tag_array
);

   localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
   localparam int OFF_W = IDX_W + 1;

   fill_state_t       r_state;
   fill_state_t       w_next_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] w_miss_base;
   logic [IDX_W-1:0]  w_start;
   logic              w_capture;
   logic              w_issue_en;
   logic [IDX_W-1:0]  w_issue_idx;
   logic              w_issue_last;
   logic              w_issue_done;
   logic [IDX_W-1:0]  w_ret_idx;
   logic              w_ret_last;
   logic              w_ret_done;

   assign w_capture   = (r_state == ST_IDLE) && miss_detected;
   assign w_miss_base = ADDR_W'(block_base(64'(miss_address), OFF_W));

`ifdef ICACHE_FILL_CWF_EN
   assign w_start = miss_address[IDX_W:1];
`else
   assign w_start = '0;
`endif

   // Only accepted requests advance the issue sequence; a stalled request
   // is simply presented again next cycle.
   assign w_issue_en = mem_en && !mem_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_base <= '0;
      end else if (w_capture) begin
         r_base <= w_miss_base;
      end
   end

   fill_word_counter #(
      .WIDTH (IDX_W)
   ) u_issue_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_capture),
      .i_start (w_start),
      .i_en    (w_issue_en),
      .o_idx   (w_issue_idx),
      .o_last  (w_issue_last),
      .o_done  (w_issue_done)
   );

   fill_word_counter #(
      .WIDTH (IDX_W)
   ) u_return_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_capture),
      .i_start (w_start),
      .i_en    (write_data_array),
      .o_idx   (w_ret_idx),
      .o_last  (w_ret_last),
      .o_done  (w_ret_done)
   );

   //--------------------------------------------------------------------------
   // FSM: state register
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   //--------------------------------------------------------------------------
   // FSM: next state
   //--------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (miss_detected) begin
               w_next_state = ST_FILL;
            end
         end
         ST_FILL: begin
            // Leave as soon as the final word is being written so the tag
            // write lands in the very next cycle.
            if (write_data_array && w_ret_last) begin
               w_next_state = ST_TAG;
            end
         end
         ST_TAG: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   //--------------------------------------------------------------------------
   // FSM: outputs
   //--------------------------------------------------------------------------
   always_comb begin
      fsm_busy         = 1'b0;
      mem_en           = 1'b0;
      memory_address   = '0;
      cache_addr       = '0;
      fill_data        = '0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      case (r_state)
         ST_FILL: begin
            fsm_busy = 1'b1;
            if (!w_issue_done) begin
               mem_en         = 1'b1;
               memory_address = r_base | ADDR_W'({w_issue_idx, 1'b0});
            end
            // Returns beyond the last word of the block are dropped.
            if (mem_data_valid && !w_ret_done) begin
               write_data_array = 1'b1;
               fill_data        = memory_data;
               cache_addr       = r_base | ADDR_W'({w_ret_idx, 1'b0});
            end
         end
         ST_TAG: begin
            fsm_busy        = 1'b1;
            write_tag_array = 1'b1;
            cache_addr      = r_base;
         end
         default: begin
         end
      endcase
   end

   // The issue side's last-word indication is not needed: its done flag
   // alone gates further requests.
   logic w_unused;
   assign w_unused = w_issue_last;

endmodule

`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
//==============================================================================
// Module : tb_icache_fill_ctrl
// Brief  : Self-checking bench for icache_fill_ctrl: directed fills plus
//          randomized fills against a block-level reference model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_icache_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = '0;
   logic        mem_stall = 1'b0;
   logic        mem_data_valid = 1'b0;
   logic [15:0] memory_data = '0;
   logic        fsm_busy;
   logic        mem_en;
   logic [15:0] memory_address;
   logic [15:0] cache_addr;
   logic [15:0] fill_data;
   logic        write_data_array;
   logic        write_tag_array;

   always #5 clk = ~clk;

   icache_fill_ctrl #(
      .ADDR_W          (16),
      .DATA_W          (16),
      .WORDS_PER_BLOCK (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .miss_detected    (miss_detected),
      .miss_address     (miss_address),
      .mem_stall        (mem_stall),
      .mem_data_valid   (mem_data_valid),
      .memory_data      (memory_data),
      .fsm_busy         (fsm_busy),
      .mem_en           (mem_en),
      .memory_address   (memory_address),
      .cache_addr       (cache_addr),
      .fill_data        (fill_data),
      .write_data_array (write_data_array),
      .write_tag_array  (write_tag_array)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Block-level reference model: phase 0 idle, 1 filling, 2 tag write.
   int          m_phase    = 0;
   int          m_issued   = 0;
   int          m_returned = 0;
   int          m_w        = 0;
   logic [15:0] m_base     = '0;

   // Pipelined memory: accepted requests return in order after lat cycles.
   typedef struct {
      int          due;
      logic [15:0] data;
   } mem_item_t;
   mem_item_t memq[$];
   int        lat       = 4;
   int        stall_pct = 0;
   bit        stall_dir = 1'b0;
   int        stall_lo  = 0;
   int        stall_hi  = 0;
   int        cap_cyc   = 0;

   // Per-fill observations used for the literal expectations.
   int          s_req, s_wr, s_tag, s_caps, s_tag_rel, s_fall_rel, s_hold;
   logic [15:0] s_first_req, s_last_req, s_tag_addr, s_hold_addr;
   bit          s_prev_busy = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] word_addr(input int idx);
      return m_base + 16'(2 * ((m_w + idx) % 8));
   endfunction

   task automatic compare();
      bit exp_en, exp_wr, exp_tag;
      exp_en  = (m_phase == 1) && (m_issued < 8);
      exp_wr  = (m_phase == 1) && mem_data_valid && (m_returned < 8);
      exp_tag = (m_phase == 2);
      chk("fsm_busy", 32'(fsm_busy), 32'(m_phase != 0));
      chk("mem_en", 32'(mem_en), 32'(exp_en));
      chk("write_data_array", 32'(write_data_array), 32'(exp_wr));
      chk("write_tag_array", 32'(write_tag_array), 32'(exp_tag));
      if (exp_en && mem_en)
         chk("memory_address", 32'(memory_address), 32'(word_addr(m_issued)));
      if (exp_wr && write_data_array) begin
         chk("fill_cache_addr", 32'(cache_addr), 32'(word_addr(m_returned)));
         chk("fill_data", 32'(fill_data), 32'(memory_data));
      end
      if (exp_tag && write_tag_array)
         chk("tag_cache_addr", 32'(cache_addr), 32'(m_base));

      if (mem_en) begin
         if (s_req == 0) s_first_req = memory_address;
         s_last_req = memory_address;
         s_req++;
         if (memory_address == s_hold_addr) s_hold++;
      end
      if (write_data_array) s_wr++;
      if (write_tag_array) begin
         s_tag++;
         s_tag_rel  = cyc - cap_cyc;
         s_tag_addr = cache_addr;
      end
      if (s_prev_busy && !fsm_busy) s_fall_rel = cyc - cap_cyc;
      s_prev_busy = fsm_busy;
   endtask

   task automatic model_advance();
      if (rst) begin
         m_phase = 0;
         return;
      end
      case (m_phase)
         0: begin
            if (miss_detected) begin
               m_phase    = 1;
               m_base     = miss_address & 16'hFFF0;
`ifdef ICACHE_FILL_CWF_EN
               m_w        = int'(miss_address[3:1]);
`else
               m_w        = 0;
`endif
               m_issued   = 0;
               m_returned = 0;
               cap_cyc    = cyc;
               s_caps++;
            end
         end
         1: begin
            if (m_issued < 8 && !mem_stall) m_issued++;
            if (mem_data_valid && m_returned < 8) begin
               m_returned++;
               if (m_returned == 8) m_phase = 2;
            end
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic tick(input bit drv_miss, input bit drv_rst, input bit allow_extra);
      mem_item_t it;
      @(posedge clk);
      #1;
      cyc++;
      rst = drv_rst;
      if (drv_rst) m_phase = 0;
      miss_detected = drv_miss;
      if (stall_dir)
         mem_stall = ((cyc - cap_cyc) >= stall_lo) && ((cyc - cap_cyc) <= stall_hi);
      else
         mem_stall = ($urandom_range(99) < stall_pct);
      mem_data_valid = 1'b0;
      memory_data    = 16'($urandom);
      if (memq.size() > 0 && memq[0].due == cyc) begin
         mem_data_valid = 1'b1;
         memory_data    = memq[0].data;
         void'(memq.pop_front());
      end else if (allow_extra && m_phase != 1 && $urandom_range(1) == 1) begin
         mem_data_valid = 1'b1;
      end
      @(negedge clk);
      compare();
      if (mem_en && !mem_stall && !rst) begin
         it.due  = cyc + lat;
         it.data = 16'($urandom);
         memq.push_back(it);
      end
      model_advance();
   endtask

   task automatic do_fill(input logic [15:0] addr, input int l, input int spct,
                          input bit sdir, input int slo, input int shi,
                          input bit hold, input bit extra, input int rst_after,
                          input logic [15:0] hold_addr);
      int  rst_left;
      bit  rst_done;
      bit  finished;
      lat = l; stall_pct = spct; stall_dir = sdir; stall_lo = slo; stall_hi = shi;
      s_req = 0; s_wr = 0; s_tag = 0; s_caps = 0; s_tag_rel = -1; s_fall_rel = -1;
      s_hold = 0; s_hold_addr = hold_addr; s_first_req = '0; s_last_req = '0;
      s_tag_addr = '0;
      rst_left = 0; rst_done = 1'b0; finished = 1'b0;
      miss_address = addr;
      tick(1'b1, 1'b0, extra);
      for (int t = 0; t < 300; t++) begin
         if (m_phase == 0 && memq.size() == 0 && rst_left == 0) begin
            finished = 1'b1;
            break;
         end
         if (rst_after > 0 && !rst_done && m_phase == 1 && m_returned >= rst_after) begin
            rst_left = 2;
            rst_done = 1'b1;
         end
         tick(hold && (m_phase == 1), rst_left > 0, extra);
         if (rst_left > 0) rst_left--;
      end
      if (!finished) begin
         chk("fill_timeout", 32'd1, 32'd0);
         memq.delete();
      end
      tick(1'b0, 1'b0, 1'b0);
      stall_dir = 1'b0; stall_pct = 0;
   endtask

`ifdef ICACHE_FILL_CWF_EN
   localparam logic [15:0] EXP_FIRST = 16'h1236;
   localparam logic [15:0] EXP_LAST  = 16'h1234;
   localparam logic [15:0] EXP_HOLD  = 16'h123A;
`else
   localparam logic [15:0] EXP_FIRST = 16'h1230;
   localparam logic [15:0] EXP_LAST  = 16'h123E;
   localparam logic [15:0] EXP_HOLD  = 16'h1234;
`endif

   initial begin
      // Reset state.
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);

      // Basic fill, zero stall, latency 4.
      do_fill(16'h1236, 4, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 16'hFFFF);
      chk("basic_req_count", 32'(s_req), 32'd8);
      chk("basic_first_req", 32'(s_first_req), 32'(EXP_FIRST));
      chk("basic_last_req", 32'(s_last_req), 32'(EXP_LAST));
      chk("basic_write_count", 32'(s_wr), 32'd8);
      chk("basic_tag_count", 32'(s_tag), 32'd1);
      chk("basic_tag_addr", 32'(s_tag_addr), 32'h1230);
      chk("basic_tag_cycle", 32'(s_tag_rel), 32'd13);
      chk("basic_busy_fall", 32'(s_fall_rel), 32'd14);

      // Third request stalled for two cycles.
      do_fill(16'h1236, 4, 0, 1'b1, 3, 4, 1'b0, 1'b0, 0, EXP_HOLD);
      chk("stall_req_cycles", 32'(s_req), 32'd10);
      chk("stall_held_addr", 32'(s_hold), 32'd3);
      chk("stall_write_count", 32'(s_wr), 32'd8);
      chk("stall_tag_count", 32'(s_tag), 32'd1);

      // Reset after the 4th return while memory keeps returning.
      do_fill(16'h1236, 4, 0, 1'b0, 0, 0, 1'b0, 1'b0, 4, 16'hFFFF);
      chk("rst_write_count", 32'(s_wr), 32'd4);
      chk("rst_tag_count", 32'(s_tag), 32'd0);
      do_fill(16'h0040, 3, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 16'hFFFF);
      chk("post_rst_writes", 32'(s_wr), 32'd8);
      chk("post_rst_tag_addr", 32'(s_tag_addr), 32'h0040);

      // miss_detected held through the fill.
      do_fill(16'h00F0, 2, 0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 16'hFFFF);
      chk("hold_captures", 32'(s_caps), 32'd1);
      chk("hold_tag_count", 32'(s_tag), 32'd1);
      chk("hold_tag_addr", 32'(s_tag_addr), 32'h00F0);

      // Spurious valids after the 8th return.
      do_fill(16'h2222, 3, 0, 1'b0, 0, 0, 1'b0, 1'b1, 0, 16'hFFFF);
      chk("extra_write_count", 32'(s_wr), 32'd8);

`ifdef ICACHE_FILL_CWF_EN
      do_fill(16'h123A, 4, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 16'hFFFF);
      chk("cwf_first_req", 32'(s_first_req), 32'h123A);
      chk("cwf_last_req", 32'(s_last_req), 32'h1238);
      chk("cwf_tag_addr", 32'(s_tag_addr), 32'h1230);
`endif

      // Randomized fills.
      for (int i = 0; i < 30; i++) begin
         int ra;
         ra = ($urandom_range(4) == 0) ? int'($urandom_range(1, 7)) : 0;
         do_fill(16'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 40)),
                 1'b0, 0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), ra, 16'hFFFF);
         if (ra == 0) begin
            chk("rand_write_count", 32'(s_wr), 32'd8);
            chk("rand_tag_count", 32'(s_tag), 32'd1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Miss-handler for the 2-way instruction cache; the responder to the cache's miss/stall indication.
- On a miss, fetches the full 16-byte block (8 x 16-bit words) from the pipelined main memory.
- Streams each returned word into the cache data array, then writes the tag/valid entry.
- Sits between the IF-stage cache and the memory port; holds the cache busy until the block is resident.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, memory/cache word width
- WORDS_PER_BLOCK, 8, words per cache block (power of 2; offset bits = log2(WORDS_PER_BLOCK)+1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- miss_detected  in  1  cache miss (cache stall) this cycle
- miss_address  in  ADDR_W  byte address that missed
- mem_stall  in  1  memory cannot accept a request this cycle
- mem_data_valid  in  1  memory_data carries a returned word
- memory_data  in  DATA_W  word returned by memory, in request order
- fsm_busy  out  1  fill in progress
- mem_en  out  1  read request issued this cycle
- memory_address  out  ADDR_W  byte address of the request
- cache_addr  out  ADDR_W  address driven to the cache for the current fill write
- fill_data  out  DATA_W  word to write into the cache data array
- write_data_array  out  1  write fill_data at cache_addr this cycle
- write_tag_array  out  1  write tag/valid/LRU for cache_addr's block this cycle

Behaviour:
- Reset: state IDLE; counters 0; every output 0.
- States: IDLE, FILL, TAG.
- IDLE:
  - miss_detected=1 captures base = miss_address with offset bits cleared; next state FILL.
  - fsm_busy rises the next cycle.
  - mem_data_valid is ignored in IDLE.
- FILL, issue side:
  - 3-bit issue counter ic.
  - While ic has not issued all 8: mem_en=1, memory_address = base + 2*ic.
  - ic advances only when mem_stall=0; the held request repeats while stalled.
  - After the 8th accepted request: mem_en=0.
- FILL, return side:
  - 3-bit return counter rc.
  - Each mem_data_valid cycle: write_data_array=1, fill_data=memory_data, cache_addr = base + 2*rc, rc++. This is combinational, the same cycle as the valid.
  - Issue and return may overlap in the same cycle.
  - Valid beyond 8 returns is ignored.
- FILL -> TAG: on the cycle after the 8th return is written.
- TAG (exactly one cycle): write_tag_array=1, cache_addr=base, write_data_array=0; next state IDLE, fsm_busy=0 the following cycle.
- fsm_busy = 1 in FILL and TAG.
- miss_detected while busy is ignored; no second capture.
- Counter wrap: ic/rc are modulo 8. Separate done flags (issued_all, returned_all) distinguish 0 from 8.
- Reset mid-fill: immediate return to IDLE; no tag write; stale memory returns are discarded.
- Latency, zero-stall memory with latency L: tag write at cycle 1+L+8 after miss capture.

Optional Feature:
- Macro: ICACHE_FILL_CWF_EN (critical-word-first).
- Defined:
  - Issue and return sequences start at the missed word offset w = miss_address[3:1] and wrap modulo 8 within the block.
  - Address = base + 2*((w+ic) mod 8); the same mapping applies to cache_addr.
  - Tag write is unchanged.
- Undefined: always starts at offset 0; miss_address[3:1] unused.

Decomposition:
- Shared package icache_pkg:
  - fill state enum (IDLE/FILL/TAG)
  - OFFSET_W, WORD_IDX_W constants
  - block-base mask function
- One natural sub-module: fill_word_counter (3-bit count, enable, done flag, optional start offset). Instantiated twice, for issue and return.

Test Plan:
- Miss at 0x1236, no stall, latency 4 -> 8 requests 0x1230..0x123E on consecutive cycles; writes to the same addresses with data in order; one write_tag_array at cache_addr 0x1230; fsm_busy low 1+4+8+1 cycles after the miss.
- Same miss with mem_stall high on request 3 for 2 cycles -> memory_address 0x1234 held for 3 cycles; still exactly 8 writes, then tag.
- Reset asserted after 4th return, then mem_data_valid continues -> outputs 0 immediately; no writes, no tag write; next miss at 0x0040 fills cleanly.
- miss_detected held high through a fill at 0x00F0 -> exactly one fill; no second capture until IDLE.
- With ICACHE_FILL_CWF_EN, miss at 0x123A -> request order 0x123A, 0x123C, 0x123E, 0x1230 .. 0x1238; tag write at 0x1230.
- Extra mem_data_valid pulse after 8th return -> ignored; exactly 8 write_data_array pulses.
